// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data_ram handshake port between two requesters.
// Ownership is locked for bursts; a hold limit forces a yield when the other port waits.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_cs_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_cs_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        arb_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    localparam bit              FORCE_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W:0]  HOLD_LIM = (CNT_W+1)'(MAX_HOLD);

    state_t             state, state_n;
    logic               owner, owner_n;
    logic               last, last_n;
    logic [CNT_W-1:0]   hold_cnt, hold_n;

    logic               busy;
    logic               own_cs, oth_cs, own_we;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_data;
    logic [CNT_W:0]     hold_inc;
    logic               hold_hit;

    assign busy     = (state == BUSY);
    assign own_cs   = owner ? p1_cs_i   : p0_cs_i;
    assign oth_cs   = owner ? p0_cs_i   : p1_cs_i;
    assign own_we   = owner ? p1_we_i   : p0_we_i;
    assign own_addr = owner ? p1_addr_i : p0_addr_i;
    assign own_data = owner ? p1_data_i : p0_data_i;

    // Counts the ack being taken this cycle, so the limit-th ack triggers the yield.
    assign hold_inc = {1'b0, hold_cnt} + (CNT_W+1)'(1);
    assign hold_hit = FORCE_EN && mem_ack_i && (hold_inc >= HOLD_LIM) && oth_cs;

    assign mem_cs_o    = busy & own_cs;
    assign mem_we_o    = busy & own_we;
    assign mem_addr_o  = busy ? own_addr : '0;
    assign mem_data_o  = busy ? own_data : '0;
    assign p0_ack_o    = busy & ~owner & mem_ack_i;
    assign p1_ack_o    = busy &  owner & mem_ack_i;
    assign p0_data_o   = busy ? mem_data_i : '0;
    assign p1_data_o   = busy ? mem_data_i : '0;
    assign gnt_o       = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign arb_state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (p0_cs_i || p1_cs_i) begin
                    state_n = BUSY;
                    hold_n  = '0;
                    owner_n = (p0_cs_i && p1_cs_i) ? ~last : p1_cs_i;
                end
            end
            BUSY: begin
                if (mem_ack_i && (hold_cnt != '1))
                    hold_n = hold_cnt + CNT_W'(1);
                // Release and forced yield both go through IDLE for a cs-low gap.
                if (!own_cs || hold_hit) begin
                    state_n = IDLE;
                    last_n  = owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed jobs, a data_ram model,
// expected acks and grant order queued at issue time and checked by a monitor.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic [7:0]  abort_at;
    } job_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        p0_cs_i, p0_we_i, p1_cs_i, p1_we_i;
    logic [31:0] p0_addr_i, p0_data_i, p1_addr_i, p1_data_i;
    logic [31:0] p0_data_o, p1_data_o;
    logic        p0_ack_o, p1_ack_o;
    logic        mem_cs_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_ack_i;
    logic [1:0]  gnt_o, arb_state_o;

    logic        model_ack;
    logic        force_ack;
    logic [31:0] mdata;
    int          mcnt;

    logic        dcs [2];
    logic        dwe [2];
    logic [31:0] dad [2];
    logic [31:0] dwd [2];
    logic [1:0]  active;
    logic [1:0]  ack_seen;
    logic [1:0]  prev_gnt;

    int n_chk  = 0;
    int n_fail = 0;

    job_t       jq0 [$];
    job_t       jq1 [$];
    exp_t       ex0 [$];
    exp_t       ex1 [$];
    logic [1:0] eg  [$];

    assign p0_cs_i   = dcs[0];
    assign p0_we_i   = dwe[0];
    assign p0_addr_i = dad[0];
    assign p0_data_i = dwd[0];
    assign p1_cs_i   = dcs[1];
    assign p1_we_i   = dwe[1];
    assign p1_addr_i = dad[1];
    assign p1_data_i = dwd[1];
    assign mem_ack_i = model_ack | force_ack;
    assign mem_data_i = mdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_cs_i(p0_cs_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_cs_i(p1_cs_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .gnt_o(gnt_o), .arb_state_o(arb_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rdata(logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(int p, logic we, logic [31:0] a, logic [31:0] d,
                        logic last, int ab = 0);
        job_t j;
        exp_t e;
        j.we = we; j.addr = a; j.data = d; j.last = last; j.abort_at = 8'(ab);
        e.we = we; e.addr = a; e.data = we ? d : rdata(a);
        if (p == 0) begin
            jq0.push_back(j);
            if (ab == 0) ex0.push_back(e);
        end else begin
            jq1.push_back(j);
            if (ab == 0) ex1.push_back(e);
        end
    endtask

    function automatic int qsize(int p);
        return (p == 0) ? jq0.size() : jq1.size();
    endfunction

    // data_ram model: acks LAT cycles after cs rises, one ack per word
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_ack <= 1'b0;
            mcnt      <= 0;
            mdata     <= '0;
        end else if (mem_cs_o && !mem_ack_i) begin
            if (mcnt == LAT - 1) begin
                model_ack <= 1'b1;
                mdata     <= rdata(mem_addr_o);
                mcnt      <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            model_ack <= 1'b0;
            mcnt      <= 0;
        end
    end

    always @(negedge clk) ack_seen = {p1_ack_o, p0_ack_o};

    // Requesters: one job per word, cs held until ack, bursts chain on ack
    initial begin : driver
        job_t cur [2];
        int   n   [2];
        logic ld, ab;
        for (int p = 0; p < 2; p++) begin
            dcs[p] = 1'b0; dwe[p] = 1'b0; dad[p] = '0; dwd[p] = '0; n[p] = 0;
        end
        active = '0;
        forever begin
            @(posedge clk);
            #1;
            ab = 1'b0;
            for (int p = 0; p < 2; p++) begin
                ld = 1'b0;
                if (!rst) begin
                    active[p] = 1'b0;
                    dcs[p]    = 1'b0;
                    if (p == 0) jq0.delete(); else jq1.delete();
                end else if (active[p]) begin
                    if (ack_seen[p]) begin
                        if (!cur[p].last && qsize(p) != 0) ld = 1'b1;
                        else begin dcs[p] = 1'b0; active[p] = 1'b0; end
                    end else if (cur[p].abort_at != 0 && n[p] == int'(cur[p].abort_at)) begin
                        dcs[p] = 1'b0; active[p] = 1'b0; ab = 1'b1;
                    end else if (n[p] > 300) begin
                        check($sformatf("p%0d_ack_timeout", p), 64'(n[p]), 64'd0);
                        dcs[p] = 1'b0; active[p] = 1'b0;
                    end else begin
                        n[p]++;
                    end
                end else if (qsize(p) != 0) begin
                    ld = 1'b1;
                end
                if (ld) begin
                    if (p == 0) cur[p] = jq0.pop_front(); else cur[p] = jq1.pop_front();
                    dcs[p] = 1'b1; dwe[p] = cur[p].we;
                    dad[p] = cur[p].addr; dwd[p] = cur[p].data;
                    active[p] = 1'b1; n[p] = 0;
                end
            end
            if (ab) begin
                #1;
                check("abort_cs_same_cycle", 64'(mem_cs_o), 64'd0);
                check("abort_still_busy", 64'(arb_state_o), 64'd1);
            end
        end
    end

    task automatic mon(int p);
        exp_t       e;
        logic [1:0] g;
        logic [31:0] rd;
        logic       own, oth;
        g   = (p == 0) ? 2'b01 : 2'b10;
        rd  = (p == 0) ? p0_data_o : p1_data_o;
        own = (p == 0) ? p0_ack_o : p1_ack_o;
        oth = (p == 0) ? p1_ack_o : p0_ack_o;
        if ((p == 0 && ex0.size() == 0) || (p == 1 && ex1.size() == 0)) begin
            check($sformatf("p%0d_unexpected_ack", p), 64'(own), 64'd0);
        end else begin
            if (p == 0) e = ex0.pop_front(); else e = ex1.pop_front();
            check($sformatf("p%0d_addr", p), 64'(mem_addr_o), 64'(e.addr));
            check($sformatf("p%0d_we", p), 64'(mem_we_o), 64'(e.we));
            if (e.we) check($sformatf("p%0d_wdata", p), 64'(mem_data_o), 64'(e.data));
            else      check($sformatf("p%0d_rdata", p), 64'(rd), 64'(e.data));
            check($sformatf("p%0d_ack_gnt", p), 64'(gnt_o), 64'(g));
            check($sformatf("p%0d_other_ack", p), 64'(oth), 64'd0);
        end
    endtask

    // Monitor: pops expected acks and grant order whenever the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            prev_gnt = 2'b00;
        end else begin
            if (p0_ack_o) mon(0);
            if (p1_ack_o) mon(1);
            if (gnt_o != prev_gnt && gnt_o != 2'b00) begin
                check("turnaround_gap", 64'(prev_gnt), 64'd0);
                if (eg.size() == 0) check("unexpected_grant", 64'(gnt_o), 64'd0);
                else check("grant_order", 64'(gnt_o), 64'(eg.pop_front()));
            end
            prev_gnt = gnt_o;
        end
    end

    task automatic wait_idle(string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = jq0.size() == 0 && jq1.size() == 0 && ex0.size() == 0 &&
                 ex1.size() == 0 && eg.size() == 0 && active == 2'b00 &&
                 arb_state_o == 2'b00;
        end
        check({nm, "_complete"}, 64'(ok), 64'd1);
        if (!ok) begin
            jq0.delete(); jq1.delete(); ex0.delete(); ex1.delete(); eg.delete();
        end
    endtask

    initial begin : main
        logic ok;
        rst       = 1'b0;
        force_ack = 1'b0;
        #1;
        check("reset_mem_cs", 64'(mem_cs_o), 64'd0);
        check("reset_gnt", 64'(gnt_o), 64'd0);
        check("reset_state", 64'(arb_state_o), 64'd0);
        check("reset_acks", 64'({p0_ack_o, p1_ack_o}), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;

        // contention right after reset: port 0 first, then port 1
        push(0, 1'b0, 32'h10, 32'h0, 1'b1);
        push(1, 1'b0, 32'h20, 32'h0, 1'b1);
        eg.push_back(2'b01);
        eg.push_back(2'b10);
        wait_idle("contention");

        // single read with one-cycle arbitration latency
        #1;
        push(0, 1'b0, 32'h40, 32'h0, 1'b1);
        eg.push_back(2'b01);
        @(posedge clk);
        #2 check("read_idle_cycle_cs", 64'(mem_cs_o), 64'd0);
        @(posedge clk);
        #2;
        check("read_cs_next_cycle", 64'(mem_cs_o), 64'd1);
        check("read_addr", 64'(mem_addr_o), 64'h40);
        check("read_gnt", 64'(gnt_o), 64'd1);
        wait_idle("single_read");
        check("read_gnt_released", 64'(gnt_o), 64'd0);

        // round-robin: last owner was port 0, so port 1 leads
        #1;
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 1'b1);
            push(1, 1'b1, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
            eg.push_back(2'b10);
            eg.push_back(2'b01);
        end
        wait_idle("round_robin");

        // forced yield after 4 acks of an 8-word burst
        #1;
        for (int i = 0; i < 8; i++)
            push(0, 1'b0, 32'h500 + 32'(4 * i), 32'h0, i == 7);
        eg.push_back(2'b01);
        eg.push_back(2'b10);
        eg.push_back(2'b01);
        repeat (3) @(posedge clk);
        #3 push(1, 1'b1, 32'h600, 32'h1234_5678, 1'b1);
        wait_idle("forced_yield");

        // abort before ack, then a stray ack in IDLE
        #1;
        push(1, 1'b0, 32'h0A0, 32'h0, 1'b1, 1);
        eg.push_back(2'b10);
        wait_idle("abort");
        @(posedge clk);
        #2 force_ack = 1'b1;
        #1 check("stray_ack_ignored", 64'({p0_ack_o, p1_ack_o}), 64'd0);
        @(posedge clk);
        #2 force_ack = 1'b0;

        // asynchronous reset in the middle of a burst
        #1;
        for (int i = 0; i < 4; i++)
            push(0, 1'b0, 32'h700 + 32'(4 * i), 32'h0, i == 3);
        eg.push_back(2'b01);
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midreset_mem_cs", 64'(mem_cs_o), 64'd0);
        check("midreset_gnt", 64'(gnt_o), 64'd0);
        check("midreset_acks", 64'({p0_ack_o, p1_ack_o}), 64'd0);
        check("midreset_state", 64'(arb_state_o), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        ex0.delete(); ex1.delete(); eg.delete();
        rst = 1'b1;
        #1;
        push(0, 1'b0, 32'h800, 32'h0, 1'b1);
        push(1, 1'b0, 32'h900, 32'h0, 1'b1);
        eg.push_back(2'b01);
        eg.push_back(2'b10);
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
